// File: rtl/queue_ctrl_param.sv
// Circular-FIFO pointer/handshake controller for an external 1R/1W register queue.
// Optional sticky overflow/underflow checking: define QUEUE_CTRL_ERR_CHECK_EN.
module queue_ctrl_param #(
  parameter int BITS         = 2,
  parameter int SIZE         = 4,
  parameter int WIDTH        = 32,
  parameter int AFULL_THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_push_valid,
  input  logic [WIDTH-1:0] in_push_data,
  output logic             out_push_ready,
  output logic             out_pop_valid,
  output logic [WIDTH-1:0] out_pop_data,
  input  logic             in_pop_ready,
  output logic             out_wr_en,
  output logic [BITS-1:0]  out_wr_addr,
  output logic [WIDTH-1:0] out_wr_data,
  output logic [BITS-1:0]  out_rd_addr,
  input  logic [WIDTH-1:0] in_rd_data,
  output logic [BITS:0]    out_count,
  output logic             out_empty,
  output logic             out_full,
  output logic             out_almost_full,
  output logic             out_overflow,
  output logic             out_underflow
);

  localparam logic [BITS:0]   SIZE_C  = (BITS+1)'(SIZE);
  localparam logic [BITS:0]   AFULL_C = (BITS+1)'(AFULL_THRESH);
  localparam logic [BITS:0]   CNT_ONE = (BITS+1)'(1);
  localparam logic [BITS-1:0] PTR_ONE = BITS'(1);

  logic [BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [BITS:0]   count_q, count_d;
  logic            empty, full, push, pop;

  // Status comes only from the registered count, so a same-cycle pop never frees a full slot.
  assign empty = (count_q == '0);
  assign full  = (count_q == SIZE_C);
  assign push  = in_push_valid & ~full;
  assign pop   = in_pop_ready & ~empty;

  assign out_push_ready  = ~full;
  assign out_pop_valid   = ~empty;
  assign out_empty       = empty;
  assign out_full        = full;
  assign out_almost_full = (count_q >= AFULL_C);
  assign out_count       = count_q;
  assign out_wr_en       = push;
  assign out_wr_addr     = wr_ptr_q;
  assign out_wr_data     = in_push_data;
  assign out_rd_addr     = rd_ptr_q;
  assign out_pop_data    = in_rd_data;

  // Pointers wrap naturally since SIZE == 2^BITS.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef QUEUE_CTRL_ERR_CHECK_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (in_push_valid & full);
    unf_d = unf_q | (in_pop_ready & empty);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
`else
  assign out_overflow  = 1'b0;
  assign out_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_queue_ctrl_param.sv
// Scoreboard bench for queue_ctrl_param: expected data queued on accepted push,
// compared by a negedge monitor against the head presented by the DUT.
module tb_queue_ctrl_param;
  localparam int BITS = 2, SIZE = 4, WIDTH = 32, AFULL_THRESH = 3;

  logic             gclk = 1'b0;
  logic             rst;
  logic             in_push_valid, in_pop_ready;
  logic [WIDTH-1:0] in_push_data, in_rd_data;
  logic             out_push_ready, out_pop_valid, out_wr_en;
  logic [WIDTH-1:0] out_pop_data, out_wr_data;
  logic [BITS-1:0]  out_wr_addr, out_rd_addr;
  logic [BITS:0]    out_count;
  logic             out_empty, out_full, out_almost_full, out_overflow, out_underflow;

  always #5 gclk = ~gclk;

  queue_ctrl_param #(.BITS(BITS), .SIZE(SIZE), .WIDTH(WIDTH), .AFULL_THRESH(AFULL_THRESH)) dut (
    .clk(gclk), .rst(rst),
    .in_push_valid(in_push_valid), .in_push_data(in_push_data), .out_push_ready(out_push_ready),
    .out_pop_valid(out_pop_valid), .out_pop_data(out_pop_data), .in_pop_ready(in_pop_ready),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .out_rd_addr(out_rd_addr), .in_rd_data(in_rd_data), .out_count(out_count),
    .out_empty(out_empty), .out_full(out_full), .out_almost_full(out_almost_full),
    .out_overflow(out_overflow), .out_underflow(out_underflow));

  // Storage array the controller drives.
  logic [WIDTH-1:0] mem [SIZE];
  always @(posedge gclk) if (out_wr_en) mem[out_wr_addr] <= out_wr_data;
  assign in_rd_data = mem[out_rd_addr];

  // Reference model: queue of pending entries plus running push/pop totals.
  logic [WIDTH-1:0] exp_q[$];
  int  n_push = 0, n_pop = 0;
  bit  m_ovf = 0, m_unf = 0;
  int  checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    n_push = 0; n_pop = 0; m_ovf = 0; m_unf = 0;
  endtask

  always @(posedge gclk) begin
    if (rst) begin
      bit acc_push, acc_pop;
      acc_push = in_push_valid && exp_q.size() < SIZE;
      acc_pop  = in_pop_ready && exp_q.size() > 0;
`ifdef QUEUE_CTRL_ERR_CHECK_EN
      if (in_push_valid && exp_q.size() == SIZE) m_ovf = 1;
      if (in_pop_ready && exp_q.size() == 0) m_unf = 1;
`endif
      if (acc_pop) begin void'(exp_q.pop_front()); n_pop++; end
      if (acc_push) begin exp_q.push_back(in_push_data); n_push++; end
    end
  end

  // Monitor: status every cycle, head data whenever the DUT presents one.
  always @(negedge gclk) begin
    int sz;
    sz = exp_q.size();
    chk("count", out_count, sz);
    chk("empty", out_empty, sz == 0);
    chk("full", out_full, sz == SIZE);
    chk("almost_full", out_almost_full, sz >= AFULL_THRESH);
    chk("push_ready", out_push_ready, sz < SIZE);
    chk("pop_valid", out_pop_valid, sz > 0);
    chk("wr_en", out_wr_en, in_push_valid && sz < SIZE);
    chk("wr_addr", out_wr_addr, n_push % SIZE);
    chk("rd_addr", out_rd_addr, n_pop % SIZE);
    chk("overflow", out_overflow, m_ovf);
    chk("underflow", out_underflow, m_unf);
    if (out_pop_valid && sz > 0) chk("pop_data", out_pop_data, exp_q[0]);
    if (out_wr_en) chk("wr_data", out_wr_data, in_push_data);
  end

  task automatic cyc(input bit pv, input logic [WIDTH-1:0] pd, input bit pr);
    in_push_valid = pv; in_push_data = pd; in_pop_ready = pr;
    @(posedge gclk); #1;
  endtask

  initial begin
    rst = 1'b0; in_push_valid = 0; in_push_data = '0; in_pop_ready = 0;
    repeat (2) @(posedge gclk);
    #1 rst = 1'b1;

    // Fill A0..A3 with consumer stalled.
    for (int i = 0; i < 4; i++) cyc(1, 32'hA0 + i, 0);
    chk("fill_full", out_full, 1'b1);
    chk("fill_ready", out_push_ready, 1'b0);
    // Drain in order; rd_addr wraps 3 -> 0.
    for (int i = 0; i < 4; i++) cyc(0, '0, 1);
    chk("drain_empty", out_empty, 1'b1);
    chk("drain_rd_addr", out_rd_addr, 0);

    // Two entries, then 8 cycles of simultaneous push+pop.
    cyc(1, 32'hB0, 0); cyc(1, 32'hB1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 32'hC0 + i, 1);
    chk("stream_count", out_count, 2);

    // At full, push and pop together: pop taken, push refused.
    cyc(1, 32'hD0, 0); cyc(1, 32'hD1, 0);
    chk("pre_full", out_full, 1'b1);
    in_push_valid = 1; in_push_data = 32'hDEAD; in_pop_ready = 1;
    #1 chk("full_both_wr_en", out_wr_en, 1'b0);
    @(posedge gclk); #1;
    chk("full_both_count", out_count, 3);

    // Error conditions: push at full, pop-ready at empty.
    cyc(1, 32'hE0, 0);
    cyc(1, 32'hE1, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1);
    cyc(0, '0, 0);
`ifdef QUEUE_CTRL_ERR_CHECK_EN
    chk("ovf_sticky", out_overflow, 1'b1);
    chk("unf_sticky", out_underflow, 1'b1);
`else
    chk("ovf_tied", out_overflow, 1'b0);
    chk("unf_tied", out_underflow, 1'b0);
`endif

    // Asynchronous reset mid-stream at count 2.
    cyc(1, 32'hF0, 0); cyc(1, 32'hF1, 0);
    in_push_valid = 0; in_pop_ready = 0;
    @(posedge gclk); #2;
    rst = 1'b0; #1;
    chk("rst_count", out_count, 0);
    chk("rst_empty", out_empty, 1'b1);
    chk("rst_full", out_full, 1'b0);
    chk("rst_afull", out_almost_full, 1'b0);
    chk("rst_ready", out_push_ready, 1'b1);
    chk("rst_valid", out_pop_valid, 1'b0);
    chk("rst_wr_en", out_wr_en, 1'b0);
    chk("rst_ovf", out_overflow, 1'b0);
    chk("rst_unf", out_underflow, 1'b0);
    model_reset();
    @(posedge gclk); #1 rst = 1'b1;
    cyc(1, 32'h55, 0);
    chk("post_rst_data", out_pop_data, 32'h55);
    cyc(0, '0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
    for (int i = 0; i < 6; i++) cyc(0, '0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
